// File: rtl/wb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared Wishbone widths, arbiter state encoding and index helpers.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    localparam int WB_ADDR_W = 16;
    localparam int WB_DATA_W = 8;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GRANT = 2'd1;
    localparam logic [1:0] ARB_ABORT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ARB_IDLE,
        ST_GRANT = ARB_GRANT,
        ST_ABORT = ARB_ABORT
    } arb_state_t;

    // Width of an index into an n-entry vector (never zero).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_master_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin picker. Searches circularly starting
//            just after last_idx and returns the first requester as one-hot.
// Revision : 1.0  initial release
// ============================================================================
module rr_priority_pick
    import wb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // Walk the requesters in circular order; the first hit wins.
    always_comb begin
        int idx;
        idx   = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_idx) + i) % N;
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arbiter
// Brief    : Round-robin Wishbone master arbiter with per-CYC bus locking and
//            an un-acked-strobe watchdog that aborts dead slave cycles.
// Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter
    import wb_pkg::*;
#(
    parameter int         NUM_MASTERS    = 2,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] ABORT_DATA     = 8'hFF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*WB_ADDR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*WB_DATA_W-1:0] m_dat_i,
    output logic [WB_DATA_W-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [WB_ADDR_W-1:0]             s_adr_o,
    output logic [WB_DATA_W-1:0]             s_dat_o,
    input  logic [WB_DATA_W-1:0]             s_dat_i,
    input  logic                             s_ack_i,
    output logic [NUM_MASTERS-1:0]           grant_o,
    output logic                             timeout_flag_o,
    input  logic                             timeout_clr_i
);

    localparam int              IW       = idx_w(NUM_MASTERS);
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam int              CNT_W    = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);
    // Reset pointer to the last master so master 0 is searched first.
    localparam logic [IW-1:0]   LAST_RST = IW'(NUM_MASTERS - 1);

    arb_state_t               state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IW-1:0]            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     flag_q, flag_d;

    logic [NUM_MASTERS-1:0]   pick_gnt;
    logic                     pick_valid;
    logic [IW-1:0]            g_idx;

    rr_priority_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req      (m_cyc_i),
        .last_idx (last_grant_q),
        .gnt      (pick_gnt),
        .valid    (pick_valid)
    );

    // Encode the one-hot grant into an index for the datapath muxes.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) g_idx = IW'(i);
        end
    end

    // Datapath: route the granted master to the slave and responses back.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        case (state_q)
            ST_GRANT: begin
                s_cyc_o        = m_cyc_i[g_idx];
                s_stb_o        = m_stb_i[g_idx];
                s_we_o         = m_we_i[g_idx];
                s_adr_o        = m_adr_i[WB_ADDR_W*g_idx +: WB_ADDR_W];
                s_dat_o        = m_dat_i[WB_DATA_W*g_idx +: WB_DATA_W];
                m_ack_o[g_idx] = s_ack_i & m_stb_i[g_idx];
                m_dat_o        = s_dat_i;
            end
            ST_ABORT: begin
                m_ack_o[g_idx] = 1'b1;
                m_err_o[g_idx] = 1'b1;
                m_dat_o        = ABORT_DATA;
            end
            default: ;
        endcase
    end

    // Next-state: arbitration, bus lock, watchdog and sticky abort flag.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = '0;
        // An abort in the same cycle as a clear overrides the clear below.
        flag_d       = flag_q & ~timeout_clr_i;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!m_cyc_i[g_idx]) begin
                    last_grant_d = g_idx;
                    grant_d      = '0;
                    state_d      = ST_IDLE;
                end else if (s_stb_o && !s_ack_i) begin
                    if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                        state_d = ST_ABORT;
                    end else if (WDOG_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ABORT: begin
                flag_d       = 1'b1;
                last_grant_d = g_idx;
                grant_d      = '0;
                state_d      = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_RST;
            cnt_q        <= '0;
            flag_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            flag_q       <= flag_d;
        end
    end

    assign grant_o        = grant_q;
    assign timeout_flag_o = flag_q;

endmodule : wb_master_arbiter
`default_nettype wire

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares one Wishbone slave bus (16-bit address, 8-bit data) between NUM_MASTERS requesters, for example the SPI-to-Wishbone bridge and a soft-CPU/DMA master.
- Arbitration is round-robin with bus locking for the whole CYC period.
- A watchdog aborts cycles that a slave never acknowledges, so a dead address cannot hang the SPI host.
- Sits between the masters and the peripheral address decoder.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255, clk cycles a strobe may stay un-acked before abort; 0 disables the watchdog.
- ABORT_DATA, 8'hFF, read data returned to a master on abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master CYC.
- m_stb_i  in  NUM_MASTERS  per-master STB.
- m_we_i  in  NUM_MASTERS  per-master WE.
- m_adr_i  in  NUM_MASTERS*16  packed addresses; master k at [16k+15:16k].
- m_dat_i  in  NUM_MASTERS*8  packed write data; master k at [8k+7:8k].
- m_dat_o  out  8  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ACK.
- m_err_o  out  NUM_MASTERS  per-master abort indication (1-cycle pulse, coincident with ACK).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_adr_o  out  16  slave address.
- s_dat_o  out  8  slave write data.
- s_dat_i  in  8  slave read data.
- s_ack_i  in  1  slave ACK.
- grant_o  out  NUM_MASTERS  one-hot current grant (status).
- timeout_flag_o  out  1  sticky: an abort has occurred.
- timeout_clr_i  in  1  clears timeout_flag_o.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant_o=0, last_grant=NUM_MASTERS-1 (so master 0 wins first), counter=0, timeout_flag_o=0. All s_* outputs, m_ack_o and m_err_o are 0. m_dat_o=0.
- States: IDLE, GRANT, ABORT.
- IDLE:
  - Slave outputs forced to 0; s_ack_i ignored.
  - If any m_cyc_i is high, choose the first requester after last_grant in circular order; register the one-hot grant; go to GRANT.
  - Latency: request seen in cycle N -> s_cyc_o/s_stb_o high in cycle N+1.
- GRANT:
  - s_cyc/stb/we/adr/dat_o are combinational copies of granted master g's inputs.
  - m_ack_o[g] = s_ack_i & m_stb_i[g]; all other m_ack_o bits are 0.
  - m_dat_o = s_dat_i.
  - Grant is held while m_cyc_i[g] is high, even across multiple strobes.
  - When m_cyc_i[g] goes low: last_grant<=g, go to IDLE. There is always exactly one idle cycle between grants; no back-to-back handover.
  - Requests from other masters during GRANT wait. Their ack is 0 and they are never starved: the round-robin pointer advances every grant.
- Watchdog:
  - In GRANT, the counter increments each cycle s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, or when s_stb_o=0.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack -> ABORT.
  - An ack arriving on that same cycle wins: normal completion, no abort.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- ABORT (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0.
  - m_ack_o[g]=1, m_err_o[g]=1, m_dat_o=ABORT_DATA.
  - timeout_flag_o<=1; last_grant<=g; next state IDLE.
  - If master g still holds cyc, it re-arbitrates normally.
- timeout_flag_o:
  - timeout_clr_i clears it.
  - A simultaneous set (ABORT) and clear in the same cycle -> the flag ends at 1.
- Master withdrawal: a master that drops m_cyc_i mid-wait (before ack) in GRANT causes return to IDLE. A late s_ack_i is then ignored.
- No registers other than state, grant, last_grant, counter and flag. All datapath muxing is combinational.

Decomposition:
- Shared package wb_pkg:
  - WB_ADDR_W=16, WB_DATA_W=8.
  - Arbiter state encoding localparams (ARB_IDLE=2'd0, ARB_GRANT=2'd1, ARB_ABORT=2'd2).
  - Packed-slice index helper widths.
- One sub-module, rr_priority_pick: combinational round-robin picker.
  - Inputs: req vector and last_grant index.
  - Output: one-hot next grant plus valid.
  - Reused by future interrupt and DMA arbiters.

Test Plan:
- Single master: master0 writes 0x5A to 0x1234; slave acks after 3 cycles. Expect:
  - s_cyc_o high one cycle after m_cyc_i[0].
  - s_adr_o=0x1234, s_dat_o=0x5A.
  - m_ack_o=2'b01 for one cycle, m_err_o=0.
- Contention: both masters raise cyc in the same cycle after reset. Expect:
  - master0 granted first, master1 granted exactly one idle cycle after master0 drops cyc.
  - Next simultaneous request -> master1 granted first (round-robin).
- Read path: master1 reads 0x00FF; slave returns 0xC3 with ack. Expect m_dat_o=0xC3 and m_ack_o=2'b10 in the ack cycle; m_ack_o[0] stays 0 throughout.
- Timeout (TIMEOUT_CYCLES=8): master0 strobes, slave never acks. Expect, on the 9th cycle of grant:
  - m_ack_o[0]=m_err_o[0]=1, m_dat_o=0xFF, s_cyc_o=0.
  - timeout_flag_o=1, and it stays set until timeout_clr_i.
- Ack on deadline: slave acks exactly on cycle TIMEOUT_CYCLES-1. Expect a normal ack, m_err_o=0, flag unchanged.
- Reset mid-cycle: assert rst_n low while granted. Expect s_cyc_o/s_stb_o/grant_o=0 immediately (asynchronous). After release, master0 has first priority.
